// File: rtl/rram_op_counter_if.sv
// rram_op_counter_if: command and array-side signals of the RRAM operation
// sequencer. The master (command decoder) issues operations; the slave
// (rram_op_counter) returns status, addresses and array strobes.
interface rram_op_counter_if #(
  parameter int ADDR_W = 5
);
  // Command side
  logic              en;
  logic              start;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] base_add;
  logic [ADDR_W:0]   len;
  logic              abort;
  logic              verify_ok;

  // Status side
  logic              busy;
  logic              done;
  logic              fail;

  // Array / cache side
  logic [ADDR_W-1:0] cache_add;
  logic [ADDR_W-1:0] register_add;
  logic              WE_L;
  logic              RE_L;
  logic              cache_count_flag;
  logic              write_count_flag;
  logic              forming_count_flag;
  logic              read_count_flag;

  modport master (
    output en, start, mode, base_add, len, abort, verify_ok,
    input  busy, done, fail, cache_add, register_add, WE_L, RE_L,
           cache_count_flag, write_count_flag, forming_count_flag, read_count_flag
  );

  modport slave (
    input  en, start, mode, base_add, len, abort, verify_ok,
    output busy, done, fail, cache_add, register_add, WE_L, RE_L,
           cache_count_flag, write_count_flag, forming_count_flag, read_count_flag
  );
endinterface

// File: rtl/rram_op_counter.sv
// rram_op_counter: address and strobe sequencer for RRAM macro operations
// (cache load, cache-to-array write, forming, array read). Each word is one
// PULSE phase followed by one STEP phase that advances the addresses.
// Optional read-back verify with retries is compiled in by defining the
// macro VERIFY_EN; without it verify_ok is ignored and fail stays 0.
module rram_op_counter #(
  parameter int ADDR_W     = 5,
  parameter int PULSE_CYC  = 4,
  parameter int VERIFY_MAX = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  rram_op_counter_if.slave bus
);

  localparam int              PW    = $clog2(PULSE_CYC + 2);
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_R = {{ADDR_W{1'b0}}, 1'b1};

  localparam logic [1:0] M_CACHE = 2'b00;
  localparam logic [1:0] M_WRITE = 2'b01;
  localparam logic [1:0] M_FORM  = 2'b10;
  localparam logic [1:0] M_READ  = 2'b11;

`ifdef VERIFY_EN
  localparam int RW = $clog2(VERIFY_MAX + 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_PULSE  = 3'd2,
    S_STEP   = 3'd3,
    S_DONE   = 3'd4
`ifdef VERIFY_EN
    , S_VERIFY = 3'd5
`endif
  } state_e;

  state_e            state_q;
  logic [1:0]        mode_q;
  logic [ADDR_W:0]   remaining_q;
  logic [PW-1:0]     pulse_cnt_q;
  logic [ADDR_W-1:0] cache_add_q;
  logic [ADDR_W-1:0] register_add_q;
  logic              busy_q;
  logic              done_q;
  logic [3:0]        flags_q;
  logic              we_l_q;
  logic              re_l_q;
`ifdef VERIFY_EN
  logic [RW-1:0]     retry_q;
  logic              fail_q;
`endif

  logic              pulse_we;
  logic              pulse_re;
  logic [PW-1:0]     pulse_len;
  logic              pulse_last;
  logic [ADDR_W:0]   len_clamped;

  // Per-mode pulse shape: which strobe is driven and for how many cycles.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, otherwise unlisted paths would infer a latch.
    pulse_we  = 1'b0;
    pulse_re  = 1'b0;
    pulse_len = PW'(1);
    unique case (mode_q)
      M_WRITE, M_FORM: begin
        pulse_we  = 1'b1;
        pulse_len = PW'(PULSE_CYC);
      end
      M_READ:  pulse_re = 1'b1;
      default: ;
    endcase
  end

  assign pulse_last  = (pulse_cnt_q == (pulse_len - PW'(1)));
  assign len_clamped = (bus.len > DEPTH) ? DEPTH : bus.len;

  // Sequencer: state, word/pulse counters, addresses, strobes and status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      mode_q         <= M_CACHE;
      remaining_q    <= '0;
      pulse_cnt_q    <= '0;
      cache_add_q    <= '0;
      register_add_q <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      flags_q        <= '0;
      we_l_q         <= 1'b1;
      re_l_q         <= 1'b1;
`ifdef VERIFY_EN
      retry_q        <= '0;
      fail_q         <= 1'b0;
`endif
    end else if (bus.abort && (state_q != S_IDLE)) begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge register values regardless of statement order.
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      flags_q <= '0;
      we_l_q  <= 1'b1;
      re_l_q  <= 1'b1;
    end else if (bus.en) begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q        <= S_SETUP;
            mode_q         <= bus.mode;
            remaining_q    <= len_clamped;
            cache_add_q    <= '0;
            register_add_q <= bus.base_add;
            busy_q         <= 1'b1;
            flags_q        <= 4'b0001 << bus.mode;
`ifdef VERIFY_EN
            retry_q        <= '0;
            fail_q         <= 1'b0;
`endif
          end
        end

        S_SETUP: begin
          if (remaining_q == '0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            flags_q <= '0;
          end else begin
            state_q     <= S_PULSE;
            pulse_cnt_q <= '0;
            we_l_q      <= ~pulse_we;
            re_l_q      <= ~pulse_re;
          end
        end

        S_PULSE: begin
          if (pulse_last) begin
            pulse_cnt_q <= '0;
            we_l_q      <= 1'b1;
            re_l_q      <= 1'b1;
            state_q     <= S_STEP;
`ifdef VERIFY_EN
            // Write and forming words are read back before advancing.
            if (pulse_we) begin
              state_q <= S_VERIFY;
              re_l_q  <= 1'b0;
            end
`endif
          end else begin
            pulse_cnt_q <= pulse_cnt_q + PW'(1);
          end
        end

        S_STEP: begin
          cache_add_q    <= cache_add_q + ADDR_W'(1);
          register_add_q <= register_add_q + ADDR_W'(1);
          remaining_q    <= remaining_q - ONE_R;
`ifdef VERIFY_EN
          retry_q        <= '0;
`endif
          if (remaining_q == ONE_R) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            flags_q <= '0;
          end else begin
            state_q     <= S_PULSE;
            pulse_cnt_q <= '0;
            we_l_q      <= ~pulse_we;
            re_l_q      <= ~pulse_re;
          end
        end

`ifdef VERIFY_EN
        // Cycle 1 strobes RE_L, cycle 2 samples the compare result.
        S_VERIFY: begin
          if (pulse_cnt_q == '0) begin
            re_l_q      <= 1'b1;
            pulse_cnt_q <= PW'(1);
          end else begin
            pulse_cnt_q <= '0;
            if (bus.verify_ok) begin
              state_q <= S_STEP;
            end else if (retry_q == RW'(VERIFY_MAX)) begin
              state_q <= S_DONE;
              fail_q  <= 1'b1;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              flags_q <= '0;
            end else begin
              retry_q <= retry_q + RW'(1);
              state_q <= S_PULSE;
              we_l_q  <= 1'b0;
            end
          end
        end
`endif

        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Strobes are gated by en so a freeze releases the array immediately while
  // the pulse timer holds; the pulse resumes when en returns.
  assign bus.WE_L = we_l_q | ~bus.en;
  assign bus.RE_L = re_l_q | ~bus.en;

  assign bus.busy               = busy_q;
  assign bus.done               = done_q;
  assign bus.cache_add          = cache_add_q;
  assign bus.register_add       = register_add_q;
  assign bus.cache_count_flag   = flags_q[0];
  assign bus.write_count_flag   = flags_q[1];
  assign bus.forming_count_flag = flags_q[2];
  assign bus.read_count_flag    = flags_q[3];

`ifdef VERIFY_EN
  assign bus.fail = fail_q;
`else
  // Without read-back verify the compare input has no consumer.
  logic unused_verify;
  assign unused_verify = bus.verify_ok ^ (VERIFY_MAX == 0);
  assign bus.fail      = 1'b0;
`endif

endmodule

// File: tb/tb_rram_op_counter.sv
// tb_rram_op_counter: table-driven, hand-sequenced and randomized checks of
// rram_op_counter against a word/cycle-count model of the operation.
module tb_rram_op_counter;

  localparam int ADDR_W     = 5;
  localparam int PULSE_CYC  = 4;
  localparam int VERIFY_MAX = 3;
  localparam int DEPTH      = 1 << ADDR_W;
  localparam int BUDGET     = 400;
`ifdef VERIFY_EN
  localparam int VX  = 2;   // extra cycles per write/forming word
  localparam int VRE = 1;   // extra RE_L cycles per write/forming word
`else
  localparam int VX  = 0;
  localparam int VRE = 0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  rram_op_counter_if #(.ADDR_W(ADDR_W)) bus ();

  rram_op_counter #(
    .ADDR_W    (ADDR_W),
    .PULSE_CYC (PULSE_CYC),
    .VERIFY_MAX(VERIFY_MAX)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    int base;
    int len;
    int lat;        // cycles from the start cycle to the done cycle
    int we_low;
    int re_low;
    int fin_reg;
    int fin_cache;
  } vec_t;

  typedef struct {
    int lat;
    int we_low;
    int re_low;
    int fin_reg;
    int fin_cache;
    int busy_cyc;
    int addr_err;
    int flag_err;
    int strobe_err;
    int post_done_err;
    int fail_seen;
  } res_t;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic bit is_wr(input logic [1:0] m);
    return (m == 2'b01) || (m == 2'b10);
  endfunction

  // Reference: N words, each costing its pulse plus one step, plus setup/done.
  function automatic vec_t model(input logic [1:0] m, input int base, input int ln);
    vec_t e;
    int   n = (ln > DEPTH) ? DEPTH : ln;
    int   p = is_wr(m) ? PULSE_CYC : 1;
    e.mode      = m;
    e.base      = base;
    e.len       = ln;
    e.lat       = 2 + n * (p + 1) + (is_wr(m) ? n * VX : 0);
    e.we_low    = is_wr(m) ? n * p : 0;
    e.re_low    = (m == 2'b11) ? n : (is_wr(m) ? n * VRE : 0);
    e.fin_reg   = (base + n) % DEPTH;
    e.fin_cache = n % DEPTH;
    return e;
  endfunction

  // Hand-computed table rows assume no verify phase; add it when compiled in.
  function automatic vec_t with_verify(input vec_t v);
    vec_t e = v;
    int   n = (v.len > DEPTH) ? DEPTH : v.len;
    if (is_wr(v.mode)) begin
      e.lat    = v.lat + n * VX;
      e.re_low = v.re_low + n * VRE;
    end
    return e;
  endfunction

  // Issue one command and observe it cycle by cycle until done.
  task automatic run_cmd(input logic [1:0] m, input int base, input int ln,
                         input int restart_k, input int freeze_k, output res_t r);
    logic prev_low = 1'b0;
    logic cur_low;
    int   pulse_i  = 0;
    logic [3:0] exp_flags;
    logic [3:0] act_flags;
    r = '{-1, 0, 0, -1, -1, 0, 0, 0, 0, 0, 0};
    @(negedge clk);
    bus.mode     = m;
    bus.base_add = ADDR_W'(base);
    bus.len      = (ADDR_W + 1)'(ln);
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k <= BUDGET; k++) begin
      if (!bus.WE_L && !bus.RE_L) r.strobe_err++;
      if (!bus.en && (!bus.WE_L || !bus.RE_L)) r.strobe_err++;
      if (!bus.en && (int'(bus.register_add) != base % DEPTH)) r.addr_err++;
      r.we_low   += int'(!bus.WE_L);
      r.re_low   += int'(!bus.RE_L);
      r.busy_cyc += int'(bus.busy);
      exp_flags = bus.busy ? (4'b0001 << m) : 4'b0000;
      act_flags = {bus.read_count_flag, bus.forming_count_flag,
                   bus.write_count_flag, bus.cache_count_flag};
      if (act_flags != exp_flags) r.flag_err++;
      if (bus.en) begin
        cur_low = (m == 2'b11) ? !bus.RE_L : !bus.WE_L;
        if (cur_low && !prev_low) begin
          if (int'(bus.register_add) != (base + pulse_i) % DEPTH) r.addr_err++;
          if (int'(bus.cache_add) != pulse_i % DEPTH) r.addr_err++;
          pulse_i++;
        end
        prev_low = cur_low;
      end
      if (bus.done) begin
        r.lat       = k;
        r.fin_reg   = int'(bus.register_add);
        r.fin_cache = int'(bus.cache_add);
        r.fail_seen = int'(bus.fail);
        @(negedge clk);
        if (bus.done || bus.busy || !bus.WE_L || !bus.RE_L) r.post_done_err++;
        break;
      end
      // Disturbances for the multi-cycle corner cases.
      if (restart_k > 0 && k == restart_k) begin
        bus.start    = 1'b1;
        bus.mode     = 2'b11;
        bus.base_add = ADDR_W'(20);
        bus.len      = (ADDR_W + 1)'(5);
      end else if (restart_k > 0 && k == restart_k + 1) begin
        bus.start    = 1'b0;
        bus.mode     = m;
        bus.base_add = ADDR_W'(base);
        bus.len      = (ADDR_W + 1)'(ln);
      end
      if (freeze_k > 0 && k == freeze_k)     bus.en = 1'b0;
      if (freeze_k > 0 && k == freeze_k + 3) bus.en = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic run_and_compare(input string tag, input vec_t e,
                                 input int restart_k, input int freeze_k);
    res_t r;
    run_cmd(e.mode, e.base, e.len, restart_k, freeze_k, r);
    check($sformatf("%s latency", tag),   r.lat,           e.lat);
    check($sformatf("%s we_low", tag),    r.we_low,        e.we_low);
    check($sformatf("%s re_low", tag),    r.re_low,        e.re_low);
    check($sformatf("%s fin_reg", tag),   r.fin_reg,       e.fin_reg);
    check($sformatf("%s fin_cache", tag), r.fin_cache,     e.fin_cache);
    check($sformatf("%s busy_cyc", tag),  r.busy_cyc,      e.lat - 1);
    check($sformatf("%s addr_err", tag),  r.addr_err,      0);
    check($sformatf("%s flag_err", tag),  r.flag_err,      0);
    check($sformatf("%s strobe", tag),    r.strobe_err,    0);
    check($sformatf("%s done_pulse", tag), r.post_done_err, 0);
    check($sformatf("%s fail", tag),      r.fail_seen,     0);
  endtask

  // Watchdog so the run always ends even if the stimulus stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   done_cnt;
    logic [1:0] rm;
    int   rb;
    int   rl;
`ifdef VERIFY_EN
    res_t vr;
`endif

    bus.en        = 1'b1;
    bus.start     = 1'b0;
    bus.mode      = 2'b00;
    bus.base_add  = '0;
    bus.len       = '0;
    bus.abort     = 1'b0;
    bus.verify_ok = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst busy",  bus.busy, 0);
    check("rst done",  bus.done, 0);
    check("rst fail",  bus.fail, 0);
    check("rst WE_L",  bus.WE_L, 1);
    check("rst RE_L",  bus.RE_L, 1);
    check("rst reg",   bus.register_add, 0);
    check("rst cache", bus.cache_add, 0);
    check("rst flags", {bus.read_count_flag, bus.forming_count_flag,
                        bus.write_count_flag, bus.cache_count_flag}, 0);
    rst_n = 1'b1;

    // Directed vectors: mode, base, len, latency, WE low, RE low, final reg, final cache
    vecs[0] = '{2'b01,  2,  3, 17,  12,  0,  5, 3};   // write, 4-cycle pulses
    vecs[1] = '{2'b11, 30,  4, 10,   0,  4,  2, 4};   // read with address wrap
    vecs[2] = '{2'b00,  7,  0,  2,   0,  0,  7, 0};   // zero length
    vecs[3] = '{2'b10, 31,  1,  7,   4,  0,  0, 1};   // forming, single word, wrap
    vecs[4] = '{2'b00,  5,  2,  6,   0,  0,  7, 2};   // cache load, no strobes
    vecs[5] = '{2'b11,  0, 40, 66,   0, 32,  0, 0};   // len clamped to full depth
    for (int i = 0; i < 6; i++) begin
      run_and_compare($sformatf("vec%0d", i), with_verify(vecs[i]), 0, 0);
    end

    // start pulsed while busy is ignored
    run_and_compare("restart", with_verify('{2'b01, 4, 2, 12, 8, 0, 6, 2}), 5, 0);

    // en low for 3 cycles mid-pulse: strobe released, pulse completes afterwards
    run_and_compare("freeze", with_verify('{2'b10, 3, 2, 15, 8, 0, 5, 2}), 0, 3);

    // abort during STEP of the first word: IDLE next cycle, no done
    @(negedge clk);
    bus.mode = 2'b10; bus.base_add = ADDR_W'(3); bus.len = (ADDR_W + 1)'(3);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5 + VX) @(negedge clk);
    check("abort pre busy", bus.busy, 1);
    check("abort pre WE_L", bus.WE_L, 1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort busy", bus.busy, 0);
    check("abort flag", bus.forming_count_flag, 0);
    check("abort WE_L", bus.WE_L, 1);
    done_cnt = int'(bus.done);
    repeat (6) begin
      @(negedge clk);
      done_cnt += int'(bus.done) + int'(bus.busy);
    end
    check("abort no done", done_cnt, 0);

    // asynchronous reset in the middle of a write pulse
    @(negedge clk);
    bus.mode = 2'b01; bus.base_add = ADDR_W'(9); bus.len = (ADDR_W + 1)'(3);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst pre WE_L", bus.WE_L, 0);
    rst_n = 1'b0;
    #1;
    check("midrst WE_L",  bus.WE_L, 1);
    check("midrst busy",  bus.busy, 0);
    check("midrst reg",   bus.register_add, 0);
    check("midrst cache", bus.cache_add, 0);
    check("midrst flag",  bus.write_count_flag, 0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef VERIFY_EN
    // verify_ok held low: one pulse plus VERIFY_MAX retries, then fail and done
    bus.verify_ok = 1'b0;
    run_cmd(2'b01, 6, 2, 0, 0, vr);
    bus.verify_ok = 1'b1;
    check("verify we_low",  vr.we_low, (VERIFY_MAX + 1) * PULSE_CYC);
    check("verify fail",    vr.fail_seen, 1);
    check("verify reg",     vr.fin_reg, 6);
    check("verify latency", vr.lat, 2 + (VERIFY_MAX + 1) * (PULSE_CYC + 2));
`endif

    // Randomized commands against the model
    for (int i = 0; i < 20; i++) begin
      rm = 2'($urandom_range(0, 3));
      rb = int'($urandom_range(0, DEPTH - 1));
      rl = int'($urandom_range(0, DEPTH + 2));
      run_and_compare($sformatf("rnd%0d", i), model(rm, rb, rl), 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rram_op_counter.md
Name: rram_op_counter

Overview:
Parametrised sequencer/address counter for RRAM macro operations. Generates cache and array addresses plus active-low array strobes for four modes: cache load, cache-to-array write, forming, and array read. Sits between the command decoder and the RRAM array/cache datapath. Generalises the fixed 5-bit state counter with programmable base, length, pulse width and a read mode.

Parameters:
ADDR_W, 5, width of cache_add and register_add; array and cache depth is 2^ADDR_W
PULSE_CYC, 4, WE_L low time in cycles for write and forming pulses (>=1)
VERIFY_MAX, 3, maximum retries per word under VERIFY_EN (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  global enable; 0 freezes the FSM
start  in  1  command strobe, sampled in IDLE only
mode  in  2  00 cache load, 01 write cache->array, 10 forming, 11 read
base_add  in  ADDR_W  first array address
len  in  ADDR_W+1  word count, 0..2^ADDR_W
abort  in  1  terminate the current operation
verify_ok  in  1  read-back compare result (used only with VERIFY_EN)
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse
fail  out  1  verify failure, sticky until the next start
cache_add  out  ADDR_W  cache word index
register_add  out  ADDR_W  array address
WE_L  out  1  array write strobe, active low
RE_L  out  1  array read strobe, active low
cache_count_flag / write_count_flag / forming_count_flag / read_count_flag  out  1 each  high while busy in modes 00/01/10/11

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, fail and all count flags = 0; cache_add and register_add = 0; WE_L = RE_L = 1. Takes effect immediately, including mid-pulse.
- States: IDLE, SETUP, PULSE, STEP, DONE (plus VERIFY under the macro).
- IDLE: when en=1 and start=1, go to SETUP. Start is ignored in all other states.
- SETUP, 1 cycle:
  - Latch mode and remaining = min(len, 2^ADDR_W).
  - cache_add = 0; register_add = base_add.
  - busy = 1; flag for the latched mode = 1.
  - remaining = 0: go to DONE. Otherwise go to PULSE.
- PULSE:
  - Modes 01/10: WE_L = 0 for exactly PULSE_CYC cycles.
  - Mode 11: RE_L = 0 for 1 cycle.
  - Mode 00: 1 cycle, no strobe.
  - Then go to STEP.
- STEP, 1 cycle, strobes high:
  - cache_add += 1.
  - register_add += 1, modulo 2^ADDR_W (wraps 31 -> 0 at default).
  - remaining -= 1.
  - remaining = 0: go to DONE. Otherwise go to PULSE.
- DONE, 1 cycle: done = 1, busy = 0, flags = 0, then IDLE. Addresses hold their final values.
- Latency: 2 + N*(P+1) cycles from the start sample to done, where N = words and P = pulse cycles (P = PULSE_CYC for 01/10, 1 for 00/11).
- en = 0 in any state:
  - Hold state, counters and pulse timer.
  - WE_L and RE_L are forced high.
  - On return to en = 1, the pulse resumes and completes its remaining cycles.
- abort = 1 in any non-IDLE state: next cycle IDLE, busy = 0, flags = 0, strobes high, no done pulse, addresses hold. abort has priority over en.
- Strobes never both low. A strobe never stays low across IDLE.

Optional Feature:
VERIFY_EN defined:
- Modes 01/10 only: after each PULSE, enter VERIFY for 2 cycles: RE_L = 0 in cycle 1, verify_ok sampled in cycle 2.
- verify_ok = 1: go to STEP.
- verify_ok = 0: re-pulse the same word, up to VERIFY_MAX retries.
- Retries exhausted: fail = 1, then DONE, skipping the remaining words.
VERIFY_EN undefined:
- No VERIFY state; verify_ok is ignored; fail is tied 0.

Test Plan:
1. Reset mid-operation: rst_n low during a mode 01 PULSE -> WE_L = 1, busy = 0, addresses 0 in the same cycle.
2. Write, mode 01, base 2, len 3, PULSE_CYC 4 -> register_add 2, 3, 4, then 5; WE_L low for 4-cycle groups; done exactly 17 cycles after start; cache_add final = 3.
3. Wrap, mode 11, base 30, len 4 -> register_add 30, 31, 0, 1; four single-cycle RE_L pulses; read_count_flag high throughout busy.
4. Zero length and ignored start:
   - len = 0 -> done 2 cycles after start, no strobes.
   - start pulsed while busy -> no effect.
5. Freeze and abort in mode 10:
   - en = 0 for 3 cycles mid-pulse -> WE_L high and counters frozen; the pulse then finishes its remaining cycles.
   - abort during STEP -> IDLE next cycle, no done pulse.
6. VERIFY_EN, VERIFY_MAX 3, verify_ok held 0 on word 0 -> 4 WE_L pulses, then fail = 1 and done; register_add still equals base.
